// File: rtl/alu_reg_seq_pkg.sv
// Shared constants and types for the alu_reg_seq command sequencer.
// Optional overflow trap is enabled by defining ALU_REG_SEQ_OF_TRAP_EN.
package alu_reg_seq_pkg;

  localparam int DW_DEF  = 32;
  localparam int AW_DEF  = 5;
  localparam int OPW_DEF = 4;

  localparam logic [1:0] KIND_ALU  = 2'd0;
  localparam logic [1:0] KIND_LOAD = 2'd1;
  localparam logic [1:0] KIND_READ = 2'd2;
  localparam logic [1:0] KIND_RSVD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/alu_reg_seq.sv
// Command sequencer driving a register-file/ALU datapath: read -> execute -> writeback -> respond.
// Define ALU_REG_SEQ_OF_TRAP_EN to suppress writeback and flag rsp_err on ALU overflow.
module alu_reg_seq
  import alu_reg_seq_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_kind,
  input  logic [OPW-1:0] cmd_op,
  input  logic [AW-1:0]  cmd_rs,
  input  logic [AW-1:0]  cmd_rt,
  input  logic [AW-1:0]  cmd_rd,
  input  logic [DW-1:0]  cmd_data,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_result,
  output logic           rsp_zf,
  output logic           rsp_of,
  output logic           rsp_err,
  output logic [AW-1:0]  dp_w_addr,
  output logic [AW-1:0]  dp_r_addr_a,
  output logic [AW-1:0]  dp_r_addr_b,
  output logic [OPW-1:0] dp_alu_op,
  output logic           dp_write_reg,
  output logic           dp_write_f,
  output logic [DW-1:0]  dp_w_data,
  input  logic [DW-1:0]  dp_r_data_a,
  input  logic           dp_zf,
  input  logic           dp_of,
  input  logic [DW-1:0]  dp_f,
  output logic [15:0]    cmd_count
);

  state_e         state_q, state_d;
  logic           cmd_ready_q, cmd_ready_d;
  logic [1:0]     kind_q, kind_d;
  logic [OPW-1:0] op_q, op_d;
  logic [AW-1:0]  rs_q, rs_d;
  logic [AW-1:0]  rt_q, rt_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [DW-1:0]  data_q, data_d;
  logic [DW-1:0]  result_q, result_d;
  logic           zf_q, zf_d;
  logic           of_q, of_d;
  logic           err_q, err_d;
  logic [15:0]    count_q, count_d;
  logic           wb_en;

  always_comb begin
    // NOTE: every variable starts from its held value, so no branch can leave one unassigned and infer a latch.
    state_d  = state_q;
    kind_d   = kind_q;
    op_d     = op_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    data_d   = data_q;
    result_d = result_q;
    zf_d     = zf_q;
    of_d     = of_q;
    err_d    = err_q;
    count_d  = count_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          kind_d  = cmd_kind;
          op_d    = cmd_op;
          rs_d    = cmd_rs;
          rt_d    = cmd_rt;
          rd_d    = cmd_rd;
          data_d  = cmd_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = '0;
        zf_d     = 1'b0;
        of_d     = 1'b0;
        err_d    = 1'b0;
        unique case (kind_q)
          KIND_ALU: begin
            result_d = dp_f;
            zf_d     = dp_zf;
            of_d     = dp_of;
`ifdef ALU_REG_SEQ_OF_TRAP_EN
            err_d    = dp_of;
`else
            err_d    = 1'b0;
`endif
            state_d  = WB;
          end
          KIND_LOAD: begin
            result_d = data_q;
            state_d  = WB;
          end
          KIND_READ: begin
            result_d = dp_r_data_a;
            state_d  = RESP;
          end
          KIND_RSVD: begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        endcase
      end
      WB: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          count_d = count_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready is registered so the cycle right after reset still shows all outputs low.
    cmd_ready_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      kind_q      <= '0;
      op_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      data_q      <= '0;
      result_q    <= '0;
      zf_q        <= 1'b0;
      of_q        <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      kind_q      <= kind_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      result_q    <= result_d;
      zf_q        <= zf_d;
      of_q        <= of_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  // For ALU/LOAD err_q is only ever set by the overflow trap, so it doubles as the suppress flag.
  assign wb_en = (rd_q != '0) && !err_q;

  always_comb begin
    dp_r_addr_a  = '0;
    dp_r_addr_b  = '0;
    dp_alu_op    = '0;
    dp_w_addr    = '0;
    dp_write_reg = 1'b0;
    dp_write_f   = 1'b0;
    dp_w_data    = '0;
    rsp_valid    = 1'b0;
    rsp_result   = '0;
    rsp_zf       = 1'b0;
    rsp_of       = 1'b0;
    rsp_err      = 1'b0;

    if (state_q == EXEC || state_q == WB) begin
      dp_r_addr_a = rs_q;
      dp_r_addr_b = rt_q;
      dp_alu_op   = op_q;
    end

    if (state_q == WB) begin
      dp_w_addr    = rd_q;
      dp_write_f   = (kind_q == KIND_ALU);
      dp_w_data    = (kind_q == KIND_LOAD) ? data_q : '0;
      // Gated by rst so a reset landing on the WB edge never commits the write.
      dp_write_reg = wb_en && !rst;
    end

    if (state_q == RESP) begin
      rsp_valid  = 1'b1;
      rsp_result = result_q;
      rsp_zf     = zf_q;
      rsp_of     = of_q;
      rsp_err    = err_q;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign cmd_count = count_q;

endmodule
